// File: rtl/control_unit.sv
// Hardwired multi-cycle controller for the ALU system datapath: INIT, two-byte fetch, one execute cycle.
// Optional conditional branches (BEQ/BNE on the Z flag) are enabled by defining CU_COND_BRANCH_EN.
module control_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted,
    output logic [2:0]  DebugState
);

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        EXEC    = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t state;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [3:0] rdSel;
    logic       takeBranch;

    assign op    = IROut[15:12];
    assign rd    = IROut[11:10];
    assign rs1   = IROut[9:8];
    assign rs2   = IROut[7:6];
    assign rdSel = ~(4'b1000 >> rd);

    assign DebugState = state;

`ifdef CU_COND_BRANCH_EN
    logic unusedFlags;
    assign unusedFlags = ^ALUOutFlag[2:0];
    assign takeBranch  = (op == 4'h9) ||
                         (op == 4'hA && ALUOutFlag[3]) ||
                         (op == 4'hB && !ALUOutFlag[3]);
`else
    logic unusedFlags;
    assign unusedFlags = ^ALUOutFlag;
    assign takeBranch  = (op == 4'h9);
`endif

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state <= INIT;
        end else begin
            case (state)
                INIT:    state <= FETCH_L;
                FETCH_L: state <= FETCH_H;
                FETCH_H: state <= EXEC;
                EXEC:    state <= (op == 4'hF) ? HALT : FETCH_L;
                HALT:    state <= HALT;
                default: state <= INIT;
            endcase
        end
    end

    // Outputs are a pure decode of state and IR; every field starts from its idle value.
    always_comb begin
        RF_OutASel  = 2'b00;
        RF_OutBSel  = 2'b00;
        RF_FunSel   = 2'b00;
        RF_RegSel   = 4'b1111;
        ALU_FunSel  = 4'b0000;
        ARF_OutCSel = 2'b00;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b111;
        IR_LH       = 1'b0;
        IR_Enable   = 1'b0;
        IR_Funsel   = 2'b00;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxBSel     = 2'b00;
        MuxCSel     = 1'b0;
        Halted      = 1'b0;
        case (state)
            INIT: begin
                RF_FunSel  = 2'b11;
                RF_RegSel  = 4'b0000;
                ARF_FunSel = 2'b11;
                ARF_RegSel = 3'b000;
            end
            FETCH_L, FETCH_H: begin
                ARF_OutDSel = 2'b00;
                Mem_CS      = 1'b0;
                IR_Enable   = 1'b1;
                IR_LH       = (state == FETCH_H);
                IR_Funsel   = 2'b10;
                ARF_FunSel  = 2'b01;
                ARF_RegSel  = 3'b011;
            end
            EXEC: begin
                case (op)
                    4'h1: begin
                        MuxASel   = 2'b10;
                        RF_FunSel = 2'b10;
                        RF_RegSel = rdSel;
                    end
                    4'h2: begin
                        ARF_OutDSel = 2'b01;
                        Mem_CS      = 1'b0;
                        MuxASel     = 2'b01;
                        RF_FunSel   = 2'b10;
                        RF_RegSel   = rdSel;
                    end
                    4'h3: begin
                        RF_OutASel  = rs1;
                        ARF_OutDSel = 2'b01;
                        Mem_CS      = 1'b0;
                        Mem_WR      = 1'b1;
                    end
                    4'h4: begin
                        MuxBSel    = 2'b10;
                        ARF_FunSel = 2'b10;
                        ARF_RegSel = 3'b101;
                    end
                    4'h5, 4'h6, 4'h7, 4'h8: begin
                        RF_OutASel = rs1;
                        RF_OutBSel = rs2;
                        case (op)
                            4'h5:    ALU_FunSel = 4'b0100;
                            4'h6:    ALU_FunSel = 4'b0110;
                            4'h7:    ALU_FunSel = 4'b0111;
                            default: ALU_FunSel = 4'b1000;
                        endcase
                        RF_FunSel = 2'b10;
                        RF_RegSel = rdSel;
                    end
                    default: ;
                endcase
                // Branch target comes from the immediate byte and lands in PC at the end of EXEC.
                if (takeBranch) begin
                    MuxBSel    = 2'b10;
                    ARF_FunSel = 2'b10;
                    ARF_RegSel = 3'b011;
                end
            end
            HALT: Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small datapath model runs the controller, an instruction-level model predicts results.
// Define CU_COND_BRANCH_EN for both bench and RTL to exercise the conditional-branch build.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, ALU_FunSel;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
    logic [2:0]  ARF_RegSel;
    logic        IR_LH, IR_Enable;
    logic [1:0]  IR_Funsel;
    logic        Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel, Halted;
    logic [2:0]  dbgStateUnused;

    int total = 0;
    int bad = 0;

`ifdef CU_COND_BRANCH_EN
    localparam bit condEn = 1'b1;
    localparam logic [7:0] finalPc = 8'h42;
`else
    localparam bit condEn = 1'b0;
    localparam logic [7:0] finalPc = 8'h20;
`endif

    control_unit dut (
        .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALUOutFlag(ALUOutFlag),
        .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
        .RF_RegSel(RF_RegSel), .ALU_FunSel(ALU_FunSel), .ARF_OutCSel(ARF_OutCSel),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .IR_LH(IR_LH), .IR_Enable(IR_Enable), .IR_Funsel(IR_Funsel), .Mem_WR(Mem_WR),
        .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
        .Halted(Halted), .DebugState(dbgStateUnused)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program image: little-endian 16-bit words at even addresses, everything else NOP.
    function automatic logic [15:0] wordAt(input logic [7:0] a);
        case (a)
            8'h00: return 16'h1005;  // LDI R1,05
            8'h02: return 16'h1003;  // LDI R1,03
            8'h04: return 16'h1404;  // LDI R2,04
            8'h06: return 16'h5840;  // ADD R3,R1,R2
            8'h08: return 16'h4060;  // LDAR 60
            8'h0A: return 16'h3200;  // ST R3
            8'h0C: return 16'h6000;  // SUB R1,R1,R1
            8'h0E: return 16'hA030;  // BEQ 30
            8'h10: return 16'h7D80;  // AND R4,R2,R3
            8'h12: return 16'h8180;  // OR R1,R2,R3
            8'h14: return 16'h2400;  // LD R2
            8'h16: return 16'hC000;  // undefined
            8'h18: return 16'hB040;  // BNE 40
            8'h1A: return 16'h901E;  // BRA 1E
            8'h1C: return 16'hF000;
            8'h1E: return 16'hF000;
            8'h30: return 16'h9010;  // BRA 10
            8'h40: return 16'hF000;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [7:0] regNext(input logic [7:0] r, input logic [1:0] f, input logic [7:0] d);
        case (f)
            2'b00:   return r - 8'd1;
            2'b01:   return r + 8'd1;
            2'b10:   return d;
            default: return 8'h00;
        endcase
    endfunction

    // Datapath model driven by the controller outputs
    logic [7:0]  mem [256];
    logic [7:0]  rf [4];
    logic [7:0]  pc, ar, sp;
    logic [15:0] ir = 16'h0000;
    logic        zf = 1'b0;
    logic [7:0]  cOut, dOut, memOut, aluA, aluB, aluOut, muxA, muxB;

    assign IROut      = ir;
    assign ALUOutFlag = {zf, 3'b000};

    always_comb begin
        cOut = (ARF_OutCSel == 2'b00) ? pc : (ARF_OutCSel == 2'b01) ? ar : sp;
        dOut = (ARF_OutDSel == 2'b00) ? pc : (ARF_OutDSel == 2'b01) ? ar : sp;
        memOut = mem[dOut];
        aluA = MuxCSel ? cOut : rf[RF_OutASel];
        aluB = rf[RF_OutBSel];
        case (ALU_FunSel)
            4'b0100: aluOut = aluA + aluB;
            4'b0110: aluOut = aluA - aluB;
            4'b0111: aluOut = aluA & aluB;
            4'b1000: aluOut = aluA | aluB;
            default: aluOut = aluA;
        endcase
        case (MuxASel)
            2'b00:   muxA = aluOut;
            2'b01:   muxA = memOut;
            2'b10:   muxA = ir[7:0];
            default: muxA = cOut;
        endcase
        case (MuxBSel)
            2'b00:   muxB = aluOut;
            2'b01:   muxB = memOut;
            default: muxB = ir[7:0];
        endcase
    end

    initial begin
        for (int a = 0; a < 256; a += 2) begin
            mem[a]     = wordAt(8'(a))[7:0];
            mem[a + 1] = wordAt(8'(a))[15:8];
        end
        forever begin
            @(posedge Clock);
            for (int i = 0; i < 4; i++)
                if (!RF_RegSel[3 - i]) rf[i] <= regNext(rf[i], RF_FunSel, muxA);
            if (!ARF_RegSel[2]) pc <= regNext(pc, ARF_FunSel, muxB);
            if (!ARF_RegSel[1]) ar <= regNext(ar, ARF_FunSel, muxB);
            if (!ARF_RegSel[0]) sp <= regNext(sp, ARF_FunSel, muxB);
            if (IR_Enable && IR_Funsel == 2'b10) begin
                if (IR_LH) ir[15:8] <= memOut;
                else       ir[7:0]  <= memOut;
            end
            if (!Mem_CS && Mem_WR) mem[dOut] <= aluOut;
            if (RF_RegSel != 4'hF && RF_FunSel == 2'b10 && MuxASel == 2'b00) zf <= (aluOut == 8'h00);
        end
    end

    // Instruction-level model plus the per-cycle compare process
    logic [47:0] exp_q[$];

    initial begin
        logic [7:0]  imem [256];
        logic [7:0]  ireg [4];
        logic [7:0]  ipc, iar, res;
        logic        iz;
        logic [15:0] ins;
        logic [3:0]  op, expRf;
        logic [2:0]  expArf;
        logic [3:0]  aluCode [4];
        logic        taken;
        int          ph;
        aluCode[0] = 4'b0100; aluCode[1] = 4'b0110; aluCode[2] = 4'b0111; aluCode[3] = 4'b1000;
        for (int a = 0; a < 256; a += 2) begin
            imem[a]     = wordAt(8'(a))[7:0];
            imem[a + 1] = wordAt(8'(a))[15:8];
        end
        ph = -1;
        iz = 1'b0;
        ipc = 8'h00; iar = 8'h00;
        for (int i = 0; i < 4; i++) ireg[i] = 8'h00;
        forever begin
            @(negedge Clock);
            case (ph)
                0: begin
                    check("init_ctl", {RF_RegSel, ARF_RegSel, Mem_CS, Mem_WR, IR_Enable, Halted}, 11'b0000_000_1_0_0_0);
                    check("init_fun", {RF_FunSel, ARF_FunSel, ARF_OutDSel, IR_LH, IR_Funsel}, 9'b11_11_00_0_00);
                end
                1, 2: begin
                    check("fetch_ctl", {RF_RegSel, ARF_RegSel, Mem_CS, Mem_WR, IR_Enable, Halted}, 11'b1111_011_0_0_1_0);
                    check("fetch_fun", {RF_FunSel, ARF_FunSel, ARF_OutDSel, IR_LH, IR_Funsel},
                          {2'b00, 2'b01, 2'b00, (ph == 2), 2'b10});
                end
                4: begin
                    check("halt_ctl", {RF_RegSel, ARF_RegSel, Mem_CS, Mem_WR, IR_Enable, Halted}, 11'b1111_111_1_0_0_1);
                    check("halt_fun", {RF_FunSel, ARF_FunSel, ARF_OutDSel, IR_LH, IR_Funsel}, 9'h000);
                end
                default: ;
            endcase
            if ((ph == 1 || ph == 4) && exp_q.size() > 0)
                check("arch_state", {pc, ar, rf[0], rf[1], rf[2], rf[3]}, exp_q.pop_front());
            if (!Reset) begin
                ph = 0;
                ipc = 8'h00; iar = 8'h00;
                for (int i = 0; i < 4; i++) ireg[i] = 8'h00;
                exp_q.delete();
                exp_q.push_back(48'h0);
            end else if (ph == 0 || ph == 1) begin
                ph++;
            end else if (ph == 2) begin
                ph = 3;
            end else if (ph == 3) begin
                ins = {imem[ipc + 8'd1], imem[ipc]};
                ipc = ipc + 8'd2;
                check("fetch_ir", IROut, ins);
                op = ins[15:12];
                taken = (op == 4'h9) || (condEn && ((op == 4'hA && iz) || (op == 4'hB && !iz)));
                expRf = 4'hF;
                if (op == 4'h1 || op == 4'h2 || (op >= 4'h5 && op <= 4'h8)) expRf[3 - ins[11:10]] = 1'b0;
                expArf = taken ? 3'b011 : (op == 4'h4) ? 3'b101 : 3'b111;
                check("exec_ctl", {RF_RegSel, ARF_RegSel, Mem_CS, Mem_WR, IR_Enable, Halted},
                      {expRf, expArf, !(op == 4'h2 || op == 4'h3), (op == 4'h3), 1'b0, 1'b0});
                if (op >= 4'h5 && op <= 4'h8) check("exec_alu", ALU_FunSel, aluCode[op - 4'h5]);
                case (op)
                    4'h1: ireg[ins[11:10]] = ins[7:0];
                    4'h2: ireg[ins[11:10]] = imem[iar];
                    4'h3: imem[iar] = ireg[ins[9:8]];
                    4'h4: iar = ins[7:0];
                    4'h5, 4'h6, 4'h7, 4'h8: begin
                        case (op)
                            4'h5:    res = ireg[ins[9:8]] + ireg[ins[7:6]];
                            4'h6:    res = ireg[ins[9:8]] - ireg[ins[7:6]];
                            4'h7:    res = ireg[ins[9:8]] & ireg[ins[7:6]];
                            default: res = ireg[ins[9:8]] | ireg[ins[7:6]];
                        endcase
                        ireg[ins[11:10]] = res;
                        iz = (res == 8'h00);
                    end
                    default: ;
                endcase
                if (taken) ipc = ins[7:0];
                exp_q.push_back({ipc, iar, ireg[0], ireg[1], ireg[2], ireg[3]});
                ph = (op == 4'hF) ? 4 : 1;
            end
        end
    end

    // Directed sequence with hand-computed expectations
    initial begin
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        check("lit_init", {RF_RegSel, ARF_RegSel, RF_FunSel, ARF_FunSel}, 11'b0000_000_11_11);
        @(negedge Clock);
        check("lit_fetch_l", {ARF_OutDSel, IR_LH, ARF_RegSel}, 6'b00_0_011);
        @(negedge Clock);
        check("lit_fetch_h", IR_LH, 1'b1);
        @(negedge Clock);
        check("lit_ldi_exec", {MuxASel, RF_RegSel, RF_FunSel}, 8'b10_0111_10);
        @(negedge Clock);
        check("lit_ldi_r1_pc", {rf[0], pc}, 16'h0502);

        for (int i = 0; i < 300 && !Halted; i++) @(negedge Clock);
        check("halt_reached", Halted, 1'b1);
        check("lit_regs", {rf[0], rf[1], rf[2], rf[3]}, 32'h07070704);
        check("lit_store", mem[8'h60], 8'h07);
        check("lit_ar_pc", {ar, pc}, {8'h60, finalPc});

        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            check("lit_halt_hold", {Halted, RF_RegSel, ARF_RegSel, Mem_CS, IR_Enable}, 10'b1_1111_111_1_0);
        end

        @(posedge Clock); #1 Reset = 1'b0;
        @(posedge Clock); #1 Reset = 1'b1;
        @(negedge Clock);
        check("lit_reset_from_halt", {Halted, RF_RegSel, ARF_RegSel}, 8'b0_0000_000);

        @(posedge Clock); #1;
        @(posedge Clock); #1 Reset = 1'b0;
        @(negedge Clock);
        check("lit_mid_fetch", {IR_LH, IR_Enable}, 2'b11);
        @(posedge Clock); #1 Reset = 1'b1;
        @(negedge Clock);
        check("lit_reset_mid_fetch", {RF_RegSel, ARF_RegSel, IR_Enable}, 8'b0000_000_0);

        repeat (8) @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
